apl_host_rsp: RTL

//  Host-side responder for the stream buffer's host request/response interface.
//  - Accepts stream read requests (sid, ea) and tags each one.
//  - Issues the tagged reads to the host memory command channel.
//  - Tracks outstanding tags; returns per-request sid completions back to the stream buffer.
//  - Sits between the stream buffer top (o_req_* -> i_req_*, o_rsp_* -> i_rsp_*) and the host memory port.

---
 rtl/apl_host_rsp_pkg.sv | 31 +++
 rtl/apl_host_rsp_if.sv | 47 ++++
 rtl/apl_tag_fifo.sv | 51 +++++
 rtl/apl_host_rsp.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/apl_host_rsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apl_host_rsp_pkg
//  Description : Shared types and default sizes for the host-side responder
//                (tag lifecycle states, command register layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package apl_host_rsp_pkg;

    localparam int NTAGS_DEF        = 32;
    localparam int TAG_WIDTH_DEF    = $clog2(NTAGS_DEF);
    localparam int ADDR_WIDTH_DEF   = 64;
    localparam int NSTRMS_DEF       = 64;
    localparam int NSTRMS_WIDTH_DEF = $clog2(NSTRMS_DEF);

    // Lifecycle of one tag: allocated at accept, completed by the host,
    // released when its response is handed back to the stream buffer.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ISSUED = 2'd1,
        DONE   = 2'd2
    } tag_state_t;

    // Contents of the outgoing host read command register.
    typedef struct packed {
        logic [TAG_WIDTH_DEF-1:0]  tag;
        logic [ADDR_WIDTH_DEF-1:0] ea;
    } cmd_reg_t;

endpackage
`default_nettype wire

// File: rtl/apl_host_rsp_if.sv
`default_nettype none
// ============================================================================
//  Module      : apl_host_rsp_if
//  Description : Request / host command / host completion / response bundle
//                of the host-side responder. The slave modport is the
//                responder's view, master is the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apl_host_rsp_if
    import apl_host_rsp_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int NSTRMS_WIDTH = NSTRMS_WIDTH_DEF,
    parameter int TAG_WIDTH    = TAG_WIDTH_DEF
);
    logic                    i_req_v;
    logic                    i_req_r;
    logic [NSTRMS_WIDTH-1:0] i_req_sid;
    logic [ADDR_WIDTH-1:0]   i_req_ea;

    logic                    o_cmd_v;
    logic                    o_cmd_r;
    logic [TAG_WIDTH-1:0]    o_cmd_tag;
    logic [ADDR_WIDTH-1:0]   o_cmd_ea;

    logic                    i_mrsp_v;
    logic [TAG_WIDTH-1:0]    i_mrsp_tag;

    logic                    o_rsp_v;
    logic                    o_rsp_r;
    logic [NSTRMS_WIDTH-1:0] o_rsp_sid;

    logic [TAG_WIDTH:0]      o_busy_cnt;
    logic                    o_err;

    modport slave (
        input  i_req_v, i_req_sid, i_req_ea, o_cmd_r, i_mrsp_v, i_mrsp_tag, o_rsp_r,
        output i_req_r, o_cmd_v, o_cmd_tag, o_cmd_ea, o_rsp_v, o_rsp_sid, o_busy_cnt, o_err
    );

    modport master (
        output i_req_v, i_req_sid, i_req_ea, o_cmd_r, i_mrsp_v, i_mrsp_tag, o_rsp_r,
        input  i_req_r, o_cmd_v, o_cmd_tag, o_cmd_ea, o_rsp_v, o_rsp_sid, o_busy_cnt, o_err
    );

endinterface
`default_nettype wire

// File: rtl/apl_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : apl_tag_fifo
//  Description : Small register FIFO holding tags in response-release order.
//                Pointers carry one wrap bit so full and empty are distinct.
//  Revision    : 1.0 - initial release
// ============================================================================
module apl_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer advance; entries are only read while non-empty so storage needs no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/apl_host_rsp.sv
`default_nettype none
// ============================================================================
//  Module      : apl_host_rsp
//  Description : Host-side responder. Tags stream read requests, issues them
//                on the host command channel, tracks outstanding tags and
//                returns per-request sid completions to the stream buffer.
//                Build option APL_HOST_RSP_INORDER_EN: release responses in
//                request order (default: completion order).
//                The command register uses the package cmd_reg_t layout, so
//                ADDR_WIDTH/TAG_WIDTH overrides must match the package sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
module apl_host_rsp
    import apl_host_rsp_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int NSTRMS       = NSTRMS_DEF,
    parameter int NSTRMS_WIDTH = $clog2(NSTRMS),
    parameter int NTAGS        = NTAGS_DEF,
    parameter int TAG_WIDTH    = $clog2(NTAGS)
) (
    input  logic          clk,
    input  logic          reset,
    apl_host_rsp_if.slave bus
);
    tag_state_t              tag_state [NTAGS];
    logic [NSTRMS_WIDTH-1:0] sid_mem   [NTAGS];

    cmd_reg_t                cmd_q;
    logic                    cmd_v;
    logic [TAG_WIDTH:0]      busy_cnt;
    logic                    err;

    logic [NTAGS-1:0]        free_map;
    logic [TAG_WIDTH-1:0]    alloc_tag;
    logic                    any_free;
    logic                    req_r;
    logic                    accept;
    logic                    mrsp_hit;
    logic                    mrsp_bad;
    logic                    rsp_v;
    logic                    rsp_pop;

    logic                    fifo_push_req;
    logic [TAG_WIDTH-1:0]    fifo_push_tag;
    logic                    fifo_push;
    logic [TAG_WIDTH-1:0]    head_tag;
    logic                    fifo_empty;
    logic                    fifo_full;

    // Lowest-index FREE tag wins: scan from the top so the last hit is the lowest.
    always_comb begin
        free_map  = '0;
        alloc_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            free_map[i] = (tag_state[i] == FREE);
            if (tag_state[i] == FREE)
                alloc_tag = TAG_WIDTH'(i);
        end
    end

    assign any_free = |free_map;

    // A tag freed by this cycle's response is still DONE here, so it cannot
    // be handed out again until the following cycle.
    assign req_r    = any_free && (!cmd_v || bus.o_cmd_r);
    assign accept   = bus.i_req_v && req_r;

    assign mrsp_hit = bus.i_mrsp_v && (tag_state[bus.i_mrsp_tag] == ISSUED);
    assign mrsp_bad = bus.i_mrsp_v && !mrsp_hit;

    assign rsp_v    = !fifo_empty && (tag_state[head_tag] == DONE);
    assign rsp_pop  = rsp_v && bus.o_rsp_r;

`ifdef APL_HOST_RSP_INORDER_EN
    // Queue tags in request order; the head blocks until it completes.
    assign fifo_push_req = accept;
    assign fifo_push_tag = alloc_tag;
`else
    // Queue tags as they complete, so the head is always ready to release.
    assign fifo_push_req = mrsp_hit;
    assign fifo_push_tag = bus.i_mrsp_tag;
`endif

    assign fifo_push = fifo_push_req && !fifo_full;

    apl_tag_fifo #(
        .DEPTH (NTAGS),
        .WIDTH (TAG_WIDTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_tag),
        .pop       (rsp_pop),
        .head      (head_tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Tag lifecycle; accept, completion and release always touch different
    // tags because each acts on a different current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAGS; i++)
                tag_state[i] <= FREE;
        end else begin
            if (accept)
                tag_state[alloc_tag] <= ISSUED;
            if (mrsp_hit)
                tag_state[bus.i_mrsp_tag] <= DONE;
            if (rsp_pop)
                tag_state[head_tag] <= FREE;
        end
    end

    // Requesting stream of each tag, captured at allocation.
    always_ff @(posedge clk) begin
        if (accept)
            sid_mem[alloc_tag] <= bus.i_req_sid;
    end

    // Output command register: loads on accept, empties when the host takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_v <= 1'b0;
            cmd_q <= '0;
        end else if (accept) begin
            cmd_v    <= 1'b1;
            cmd_q.tag <= TAG_WIDTH_DEF'(alloc_tag);
            cmd_q.ea  <= ADDR_WIDTH_DEF'(bus.i_req_ea);
        end else if (bus.o_cmd_r) begin
            cmd_v <= 1'b0;
        end
    end

    // Allocated-tag count: up on accept, down on release, unchanged when both.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
        end else begin
            case ({accept, rsp_pop})
                2'b10:   busy_cnt <= busy_cnt + 1'b1;
                2'b01:   busy_cnt <= busy_cnt - 1'b1;
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

    // Sticky flag for completions naming a tag that is not in flight.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if (mrsp_bad)
            err <= 1'b1;
    end

    assign bus.i_req_r    = req_r;
    assign bus.o_cmd_v    = cmd_v;
    assign bus.o_cmd_tag  = TAG_WIDTH'(cmd_q.tag);
    assign bus.o_cmd_ea   = ADDR_WIDTH'(cmd_q.ea);
    assign bus.o_rsp_v    = rsp_v;
    assign bus.o_rsp_sid  = sid_mem[head_tag];
    assign bus.o_busy_cnt = busy_cnt;
    assign bus.o_err      = err;

endmodule
`default_nettype wire
